// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg: shared FSM encoding, Avalon word indices and status reset
// values for the system-ID check controller.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_WT_ID   = 3'd2,
        ST_RD_TS   = 3'd3,
        ST_WT_TS   = 3'd4,
        ST_EVAL    = 3'd5,
        ST_FAIL_TO = 3'd6
    } state_e;

    // Word indices inside the sysid slave.
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Sticky status published to the boot-ready logic.
    typedef struct packed {
        logic pass;
        logic id_mismatch;
        logic ts_mismatch;
        logic timeout_err;
    } status_t;

    localparam status_t STATUS_RST = '{
        pass:        1'b0,
        id_mismatch: 1'b0,
        ts_mismatch: 1'b0,
        timeout_err: 1'b0
    };

endpackage

// File: rtl/sysid_check_timer.sv
// sysid_check_timer: loadable up-counter with terminal-count flag. Used for the
// read timeout and, when periodic checking is built in, for the recheck interval.
module sysid_check_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] last_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    // Interval counter: load restarts at zero, then counts up and holds at last_i.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: registers are assigned with <= so every flop samples pre-edge values.
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
        end else if (en_i && !tc_o) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign tc_o = (count_q == last_i);

endmodule

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: Avalon-MM master that reads the sysid slave (ID, timestamp),
// compares both words with build-time values and publishes sticky pass/fail.
// Optional build macro SYSID_CHECK_PERIODIC_EN adds a periodic recheck every
// RECHECK_CYC idle cycles after the last done; captures are then staged so the
// published values only change at EVAL.
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECT_ID   = 32'h20150910,
    parameter logic [31:0] EXPECT_TS   = 32'h55F17042,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned RETRY_MAX   = 3,
    parameter bit          AUTO_START  = 1'b1
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    parameter int unsigned RECHECK_CYC = 2**24
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  RETRY_LIM = 4'(RETRY_MAX);

    state_e      state_q, state_d;
    logic        auto_pend_q;
    logic [3:0]  retry_q;
    status_t     status_q;
    logic        done_q;
    logic [31:0] id_q, ts_q;
    logic [31:0] cmp_id, cmp_ts;
    logic        to_tc, recheck_go, go;
    logic        id_cap, ts_cap, to_evt, retry_ok;

    // Capture happens on a wait-state valid, or on a zero-latency valid in the accept cycle.
    assign id_cap   = avm_readdatavalid &&
                      ((state_q == ST_RD_ID && !avm_waitrequest) || state_q == ST_WT_ID);
    assign ts_cap   = avm_readdatavalid &&
                      ((state_q == ST_RD_TS && !avm_waitrequest) || state_q == ST_WT_TS);
    assign to_evt   = (state_q == ST_WT_ID || state_q == ST_WT_TS) && !avm_readdatavalid && to_tc;
    assign retry_ok = (retry_q < RETRY_LIM);
    assign go       = start || auto_pend_q || recheck_go;

    sysid_check_timer #(.WIDTH(16)) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (state_q == ST_RD_ID || state_q == ST_RD_TS),
        .en_i    (state_q == ST_WT_ID || state_q == ST_WT_TS),
        .last_i  (TO_LAST),
        .tc_o    (to_tc)
    );

`ifdef SYSID_CHECK_PERIODIC_EN
    localparam logic [31:0] RECHECK_LAST = 32'(RECHECK_CYC - 1);

    logic        armed_q, recheck_tc;
    logic [31:0] cap_id_q, cap_ts_q;

    // Recheck timer only runs once a first sequence has finished.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
        end else if (state_q == ST_EVAL || state_q == ST_FAIL_TO) begin
            armed_q <= 1'b1;
        end
    end

    sysid_check_timer #(.WIDTH(32)) u_recheck (
        .clock   (clock),
        .reset_n (reset_n),
        .load_i  (state_q != ST_IDLE),
        .en_i    (armed_q),
        .last_i  (RECHECK_LAST),
        .tc_o    (recheck_tc)
    );

    assign recheck_go = armed_q && recheck_tc;

    // Staging registers keep the published words stable until the next EVAL.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_id_q <= '0;
            cap_ts_q <= '0;
        end else begin
            if (id_cap) cap_id_q <= avm_readdata;
            if (ts_cap) cap_ts_q <= avm_readdata;
        end
    end

    assign cmp_id = cap_id_q;
    assign cmp_ts = cap_ts_q;
`else
    assign recheck_go = 1'b0;
    assign cmp_id     = id_q;
    assign cmp_ts     = ts_q;
`endif

    // State register; the auto-start request lives exactly one cycle after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            auto_pend_q <= AUTO_START;
        end else begin
            state_q     <= state_d;
            auto_pend_q <= 1'b0;
        end
    end

    // Next-state logic: read, wait for data, retry on timeout, evaluate.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (go) state_d = ST_RD_ID;
            ST_RD_ID:   if (!avm_waitrequest) state_d = avm_readdatavalid ? ST_RD_TS : ST_WT_ID;
            ST_WT_ID: begin
                if (avm_readdatavalid) state_d = ST_RD_TS;
                else if (to_tc)        state_d = retry_ok ? ST_RD_ID : ST_FAIL_TO;
            end
            ST_RD_TS:   if (!avm_waitrequest) state_d = avm_readdatavalid ? ST_EVAL : ST_WT_TS;
            ST_WT_TS: begin
                if (avm_readdatavalid) state_d = ST_EVAL;
                else if (to_tc)        state_d = retry_ok ? ST_RD_ID : ST_FAIL_TO;
            end
            ST_EVAL:    state_d = ST_IDLE;
            ST_FAIL_TO: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus outputs: read strobe and address are pure functions of the state, so
    // they stay stable for as long as waitrequest stalls the transfer.
    always_comb begin
        avm_read    = 1'b0;
        avm_address = ADDR_ID;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_RD_ID: avm_read = 1'b1;
            ST_RD_TS: begin
                avm_read    = 1'b1;
                avm_address = ADDR_TS;
            end
            ST_WT_TS:  avm_address = ADDR_TS;
            default: ;
        endcase
    end

    // Datapath: retry count, captured words, sticky status and the done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_q  <= '0;
            status_q <= STATUS_RST;
            done_q   <= 1'b0;
            id_q     <= '0;
            ts_q     <= '0;
        end else begin
            done_q <= (state_q == ST_EVAL) || (state_q == ST_FAIL_TO);
            if (state_q == ST_IDLE && go) begin
                retry_q  <= '0;
                status_q <= STATUS_RST;
            end
            if (to_evt && retry_ok) retry_q <= retry_q + 4'd1;
`ifdef SYSID_CHECK_PERIODIC_EN
            if (state_q == ST_EVAL) begin
                id_q <= cap_id_q;
                ts_q <= cap_ts_q;
            end
`else
            if (id_cap) id_q <= avm_readdata;
            if (ts_cap) ts_q <= avm_readdata;
`endif
            if (state_q == ST_EVAL) begin
                status_q.id_mismatch <= (cmp_id != EXPECT_ID);
                status_q.ts_mismatch <= (cmp_ts != EXPECT_TS);
                status_q.pass        <= (cmp_id == EXPECT_ID) && (cmp_ts == EXPECT_TS);
            end
            if (state_q == ST_FAIL_TO) status_q.timeout_err <= 1'b1;
        end
    end

    assign done        = done_q;
    assign pass        = status_q.pass;
    assign id_mismatch = status_q.id_mismatch;
    assign ts_mismatch = status_q.ts_mismatch;
    assign timeout_err = status_q.timeout_err;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: directed bench for sysid_check_ctrl with a behavioural
// sysid slave (configurable stall, latency, dropped responses, stray valid).
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'h20150910;
    localparam logic [31:0] EXP_TS = 32'h55F17042;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout_err;
    logic [31:0] id_value, ts_value;

    int checks = 0;
    int failures = 0;

    // Slave configuration (written by the main process only).
    int          stall_cfg = 0;
    int          lat_cfg = 0;
    bit          drop_all = 1'b0;
    bit          drop_ts = 1'b0;
    logic [31:0] id_word = EXP_ID;
    logic [31:0] ts_word = EXP_TS;
    int          stray_cnt = 0;

    // Slave observations (written by the slave process only).
    int acc0 = 0;
    int acc1 = 0;
    int stall_bad = 0;

    always #5 clock = ~clock;

    sysid_check_ctrl #(
        .EXPECT_ID   (EXP_ID),
        .EXPECT_TS   (EXP_TS),
        .TIMEOUT_CYC (8),
        .RETRY_MAX   (2),
        .AUTO_START  (1'b0)
`ifdef SYSID_CHECK_PERIODIC_EN
        ,
        .RECHECK_CYC (100)
`endif
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .id_mismatch       (id_mismatch),
        .ts_mismatch       (ts_mismatch),
        .timeout_err       (timeout_err),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural slave: inputs for the next edge are set 1 time unit after each edge.
    initial begin : slave
        int   stall_left;
        int   lat_left;
        bit   pending;
        bit   in_stall;
        logic pend_addr;
        logic stall_addr;
        int   stray_done;
        stall_left = 0; lat_left = 0; pending = 0; in_stall = 0;
        pend_addr = 1'b0; stall_addr = 1'b0; stray_done = 0;
        forever begin
            @(posedge clock);
            #1;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
            if (!reset_n) begin
                pending  = 0;
                in_stall = 0;
                continue;
            end
            if (stray_cnt != stray_done) begin
                stray_done        = stray_cnt;
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hDEADBEEF;
            end
            if (pending) begin
                lat_left--;
                if (lat_left == 0) begin
                    pending = 0;
                    if (!(drop_all || (pend_addr && drop_ts))) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_addr ? ts_word : id_word;
                    end
                end
            end
            if (avm_read) begin
                if (!in_stall) stall_left = stall_cfg;
                else if (avm_address !== stall_addr) stall_bad++;
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                    in_stall   = 1;
                    stall_addr = avm_address;
                end else begin
                    in_stall = 0;
                    if (avm_address) acc1++; else acc0++;
                    if (lat_cfg == 0) begin
                        if (!(drop_all || (avm_address && drop_ts))) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = avm_address ? ts_word : id_word;
                        end
                    end else begin
                        pending   = 1;
                        pend_addr = avm_address;
                        lat_left  = lat_cfg;
                    end
                end
            end else if (in_stall) begin
                stall_bad++;
                in_stall = 0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Waits for done; cyc counts negedges after the start edge, gaps counts busy-low cycles.
    task automatic wait_done(input int budget, output int cyc, output int gaps);
        cyc = 0;
        gaps = 0;
        while (1) begin
            @(negedge clock);
            cyc++;
            if (done) break;
            if (!busy) gaps++;
            if (cyc >= budget) begin
                check("wait_done_budget", done, 1'b1);
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_idm"}, id_mismatch, 0);
        check({tag, "_tsm"}, ts_mismatch, 0);
        check({tag, "_to"}, timeout_err, 0);
        check({tag, "_read"}, avm_read, 0);
        check({tag, "_idv"}, id_value, 0);
        check({tag, "_tsv"}, ts_value, 0);
    endtask

    initial begin : main
        int cyc, gaps, a0, a1, sb, n;

        // Reset state
        repeat (3) @(negedge clock);
        check_all_zero("rst");
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("no_auto_busy", busy, 0);
        check("no_auto_read", avm_read, 0);

        // T1: zero-wait, zero-latency slave with matching words
        a0 = acc0; a1 = acc1;
        pulse_start();
        wait_done(50, cyc, gaps);
        check("t1_latency_le6", cyc <= 6, 1);
        check("t1_pass", pass, 1);
        check("t1_idm", id_mismatch, 0);
        check("t1_tsm", ts_mismatch, 0);
        check("t1_idv", id_value, EXP_ID);
        check("t1_tsv", ts_value, EXP_TS);
        check("t1_reads_a0", acc0 - a0, 1);
        check("t1_reads_a1", acc1 - a1, 1);
        @(negedge clock);
        check("t1_done_single", done, 0);
        check("t1_idle", busy, 0);
`ifdef SYSID_CHECK_PERIODIC_EN
        n = 1;
        while (!avm_read && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("recheck_delay", n, 100);
        wait_done(50, cyc, gaps);
        check("recheck_pass", pass, 1);
`endif

        // T2: wrong ID word
        id_word = 32'h20150911;
        pulse_start();
        wait_done(50, cyc, gaps);
        check("t2_pass", pass, 0);
        check("t2_idm", id_mismatch, 1);
        check("t2_tsm", ts_mismatch, 0);
        check("t2_idv", id_value, 32'h20150911);

        // T3: 5-cycle stall per read, latency 3; back-to-back start on done
        id_word = EXP_ID;
        stall_cfg = 5;
        lat_cfg = 3;
        sb = stall_bad;
        pulse_start();
        wait_done(100, cyc, gaps);
        check("t3_busy_gaps", gaps, 0);
        check("t3_pass", pass, 1);
        check("t3_idm", id_mismatch, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t3_restart_busy", busy, 1);
        wait_done(100, cyc, gaps);
        check("t3b_busy_gaps", gaps, 0);
        check("t3b_pass", pass, 1);
        check("t3_stall_stable", stall_bad - sb, 0);

        // T4: no read data ever; 3 attempts of 9 cycles then FAIL_TO
        stall_cfg = 0;
        lat_cfg = 0;
        drop_all = 1'b1;
        a0 = acc0; a1 = acc1;
        pulse_start();
        wait_done(100, cyc, gaps);
        check("t4_done_cycle", cyc, 28);
        check("t4_timeout", timeout_err, 1);
        check("t4_pass", pass, 0);
        check("t4_idm", id_mismatch, 0);
        check("t4_reads_a0", acc0 - a0, 3);
        check("t4_reads_a1", acc1 - a1, 0);
        @(negedge clock);
        check("t4_done_single", done, 0);

        // T5: reset while waiting on the timestamp, then a stray valid
        drop_all = 1'b0;
        drop_ts = 1'b1;
        pulse_start();
        n = 0;
        while (!(avm_read && avm_address) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t5_reached_rd_ts", avm_read && avm_address, 1);
        repeat (2) @(negedge clock);
        check("t5_busy_in_wt_ts", busy, 1);
        reset_n = 1'b0;
        @(negedge clock);
        check_all_zero("t5_rst");
        reset_n = 1'b1;
        stray_cnt++;
        repeat (4) @(negedge clock);
        check_all_zero("t5_post");

        // T6: normal sequence after the abandoned one
        drop_ts = 1'b0;
        pulse_start();
        wait_done(50, cyc, gaps);
        check("t6_pass", pass, 1);
        check("t6_tsv", ts_value, EXP_TS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
